// File: rtl/stream_pkg.sv
// ============================================================================
// Module   : stream_pkg
// Brief    : Shared framing definitions for the packet stream (packer/depacketer).
// Revision : 1.0
// ============================================================================
`default_nettype none

package stream_pkg;

  localparam int BYTE_W   = 8;
  localparam int LEN_W    = 6;
  localparam int SAMPLE_W = 12;
  localparam int TYPE_MSB = 7;
  localparam int TYPE_LSB = 6;

  typedef enum logic [1:0] {
    PKT_SAMPLE = 2'b00,
    PKT_PPS    = 2'b01,
    PKT_RESP   = 2'b10,
    PKT_RSVD   = 2'b11
  } pkt_type_e;

  typedef enum logic [1:0] {
    ST_HDR     = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CSUM    = 2'd2
  } dp_state_e;

  function automatic pkt_type_e hdr_type(input logic [BYTE_W-1:0] hdr);
    return pkt_type_e'(hdr[TYPE_MSB:TYPE_LSB]);
  endfunction

endpackage

`default_nettype wire

// File: rtl/unpacker_8to12.sv
// ============================================================================
// Module   : unpacker_8to12
// Brief    : Rebuilds 12-bit samples from a byte stream (3 bytes -> 2 samples).
// Revision : 1.0
// ============================================================================
`default_nettype none

module unpacker_8to12
  import stream_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid_i,
  input  logic [BYTE_W-1:0]   in_data_i,
  output logic                out_valid_o,
  output logic [SAMPLE_W-1:0] out_data_o
);

  logic [1:0]          phase_q, phase_d;
  logic [BYTE_W-1:0]   hold_q, hold_d;
  logic                valid_q, valid_d;
  logic [SAMPLE_W-1:0] data_q, data_d;

  always_comb begin
    phase_d = phase_q;
    hold_d  = hold_q;
    valid_d = 1'b0;
    data_d  = data_q;
    if (in_valid_i) begin
      case (phase_q)
        2'd0: begin
          hold_d  = in_data_i;
          phase_d = 2'd1;
        end
        2'd1: begin
          valid_d = 1'b1;
          data_d  = {hold_q, in_data_i[7:4]};
          hold_d  = {4'h0, in_data_i[3:0]};
          phase_d = 2'd2;
        end
        default: begin
          valid_d = 1'b1;
          data_d  = {hold_q[3:0], in_data_i};
          phase_d = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= 2'd0;
      hold_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      phase_q <= phase_d;
      hold_q  <= hold_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

endmodule

`default_nettype wire

// File: rtl/depacketer.sv
// ============================================================================
// Module   : depacketer
// Brief    : Parses framed byte stream into sample / PPS / response streams.
//            Define DEPACKETER_CHECKSUM_EN for a trailing XOR checksum byte.
// Revision : 1.0
// ============================================================================
`default_nettype none

module depacketer
  import stream_pkg::*;
#(
  parameter int ERR_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid_i,
  input  logic [BYTE_W-1:0]   in_data_i,
  output logic                in_ack_o,
  output logic                sample_valid_o,
  output logic [SAMPLE_W-1:0] sample_data_o,
  output logic                pps_valid_o,
  output logic [BYTE_W-1:0]   pps_data_o,
  output logic                resp_valid_o,
  output logic [BYTE_W-1:0]   resp_data_o,
  output logic                pkt_done_o,
  output logic                err_o,
  output logic [ERR_W-1:0]    err_count_o
);

  dp_state_e          state_q, state_d;
  pkt_type_e          type_q, type_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               pps_valid_q, pps_valid_d, resp_valid_q, resp_valid_d;
  logic [BYTE_W-1:0]  pps_data_q, pps_data_d, resp_data_q, resp_data_d;
  logic               done_q, done_d, err_q, err_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
  logic               smp_push, acc;

  assign acc      = in_valid_i & ~reset;
  assign in_ack_o = acc;

`ifdef DEPACKETER_CHECKSUM_EN
  logic [BYTE_W-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (acc) begin
      if (state_q == ST_HDR)          csum_d = in_data_i;
      else if (state_q == ST_PAYLOAD) csum_d = csum_q ^ in_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) csum_q <= '0;
    else       csum_q <= csum_d;
  end
`endif

  always_comb begin
    state_d      = state_q;
    type_d       = type_q;
    cnt_d        = cnt_q;
    pps_valid_d  = 1'b0;
    pps_data_d   = pps_data_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    smp_push     = 1'b0;
    if (acc) begin
      case (state_q)
        ST_HDR: begin
          type_d  = hdr_type(in_data_i);
          cnt_d   = in_data_i[LEN_W-1:0];
          err_d   = (hdr_type(in_data_i) == PKT_RSVD);
          state_d = ST_PAYLOAD;
        end
        ST_PAYLOAD: begin
          // Reserved-type payload falls through every arm and is dropped.
          case (type_q)
            PKT_SAMPLE: smp_push = 1'b1;
            PKT_PPS: begin
              pps_valid_d = 1'b1;
              pps_data_d  = in_data_i;
            end
            PKT_RESP: begin
              resp_valid_d = 1'b1;
              resp_data_d  = in_data_i;
            end
            default: ;
          endcase
          if (cnt_q == '0) begin
`ifdef DEPACKETER_CHECKSUM_EN
            state_d = ST_CSUM;
`else
            state_d = ST_HDR;
            done_d  = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
`ifdef DEPACKETER_CHECKSUM_EN
        ST_CSUM: begin
          err_d   = (csum_q != in_data_i);
          done_d  = 1'b1;
          state_d = ST_HDR;
        end
`endif
        default: state_d = ST_HDR;
      endcase
    end
    err_cnt_d = (err_d && (err_cnt_q != {ERR_W{1'b1}})) ? err_cnt_q + ERR_W'(1) : err_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_HDR;
      type_q       <= PKT_SAMPLE;
      cnt_q        <= '0;
      pps_valid_q  <= 1'b0;
      pps_data_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      type_q       <= type_d;
      cnt_q        <= cnt_d;
      pps_valid_q  <= pps_valid_d;
      pps_data_q   <= pps_data_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      done_q       <= done_d;
      err_q        <= err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  unpacker_8to12 u_unpack (
    .clk         (clk),
    .reset       (reset),
    .in_valid_i  (smp_push),
    .in_data_i   (in_data_i),
    .out_valid_o (sample_valid_o),
    .out_data_o  (sample_data_o)
  );

  assign pps_valid_o  = pps_valid_q;
  assign pps_data_o   = pps_data_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_data_o  = resp_data_q;
  assign pkt_done_o   = done_q;
  assign err_o        = err_q;
  assign err_count_o  = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_depacketer.sv
// ============================================================================
// Module   : tb_depacketer
// Brief    : Scoreboard bench for depacketer (honours DEPACKETER_CHECKSUM_EN).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_depacketer;

  localparam int ERR_W = 8;
`ifdef DEPACKETER_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif
  localparam int F_SMP = 1, F_PPS = 2, F_RSP = 4, F_DONE = 8, F_ERR = 16;
  // pkt_done lands on the last payload byte only when there is no checksum byte
  localparam int DN = CS ? 0 : F_DONE;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic [7:0]       in_data = 8'h00;
  logic             in_ack, sample_valid, pps_valid, resp_valid, pkt_done, err;
  logic [11:0]      sample_data;
  logic [7:0]       pps_data, resp_data;
  logic [ERR_W-1:0] err_count;

  depacketer #(.ERR_W(ERR_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid_i     (in_valid),
    .in_data_i      (in_data),
    .in_ack_o       (in_ack),
    .sample_valid_o (sample_valid),
    .sample_data_o  (sample_data),
    .pps_valid_o    (pps_valid),
    .pps_data_o     (pps_data),
    .resp_valid_o   (resp_valid),
    .resp_data_o    (resp_data),
    .pkt_done_o     (pkt_done),
    .err_o          (err),
    .err_count_o    (err_count)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [11:0] d;
    int unsigned t;
  } exp_t;

  exp_t        q [5][$];
  string       names [5] = '{"sample", "pps", "resp", "pkt_done", "err"};
  int          nvec = 0;
  int          nmis = 0;
  int          gap_max = 0;
  logic [7:0]  x_acc = 8'h00;

  // Monitor: every strobe must match the queue head both in value and cycle.
  always @(negedge clk) begin : monitor
    logic [4:0]  v;
    logic [11:0] d [5];
    exp_t        e;
    v    = {err, pkt_done, resp_valid, pps_valid, sample_valid};
    d[0] = sample_data;
    d[1] = {4'h0, pps_data};
    d[2] = {4'h0, resp_data};
    d[3] = 12'h000;
    d[4] = 12'h000;
    for (int s = 0; s < 5; s++) begin
      if (v[s]) begin
        nvec++;
        if (q[s].size() == 0) begin
          nmis++;
          $display("FAIL %s: unexpected strobe data=%h at cycle %0d, required no strobe", names[s], d[s], cyc);
        end else begin
          e = q[s].pop_front();
          if (e.d !== d[s] || e.t != cyc) begin
            nmis++;
            $display("FAIL %s: got %h at cycle %0d, required %h at cycle %0d", names[s], d[s], cyc, e.d, e.t);
          end
        end
      end else if (q[s].size() != 0 && q[s][0].t <= cyc) begin
        nvec++;
        nmis++;
        e = q[s].pop_front();
        $display("FAIL %s: no strobe at cycle %0d, required %h at cycle %0d", names[s], cyc, e.d, e.t);
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nmis++;
      $display("FAIL %s: got %h, required %h", n, act, req);
    end
  endtask

  // Called at a negedge; drives one byte, accepted at the following posedge.
  task automatic send(input logic [7:0] b, input int fl, input logic [11:0] dv);
    exp_t e;
    repeat ($urandom_range(0, gap_max)) @(negedge clk);
    for (int s = 0; s < 5; s++) begin
      if (fl[s]) begin
        e.d = (s < 3) ? dv : 12'h000;
        e.t = cyc + 1;
        q[s].push_back(e);
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    x_acc    = x_acc ^ b;
    #1 chk("in_ack", {31'd0, in_ack}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic hdr(input logic [7:0] b, input int fl);
    x_acc = 8'h00;
    send(b, fl, 12'h000);
  endtask

  task automatic tail();
    if (CS) send(x_acc, F_DONE, 12'h000);
  endtask

  task automatic drain();
    repeat (4) @(negedge clk);
    for (int s = 0; s < 5; s++) chk({"leftover ", names[s]}, q[s].size(), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    in_valid = 1'b1;
    #1 chk("in_ack in reset", {31'd0, in_ack}, 32'd0);
    in_valid = 1'b0;
    chk("reset outputs", {sample_valid, pps_valid, resp_valid, pkt_done, err, sample_data, pps_data},
        32'd0);
    chk("reset err_count", {24'd0, err_count}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // 1: sample packet of three bytes -> two samples
    hdr(8'h02, 0);
    send(8'hAB, 0, 12'h000);
    send(8'hCD, F_SMP, 12'hABC);
    send(8'hEF, F_SMP | DN, 12'hDEF);
    tail();
    drain();
    chk("err_count t1", {24'd0, err_count}, 32'd0);

    // 2: pps
    hdr(8'h40, 0);
    send(8'h5A, F_PPS | DN, 12'h05A);
    tail();
    drain();

    // 3: unpack phase carried across packets
    hdr(8'h01, 0);
    send(8'h12, 0, 12'h000);
    send(8'h34, F_SMP | DN, 12'h123);
    tail();
    hdr(8'h00, 0);
    send(8'h56, F_SMP | DN, 12'h456);
    tail();
    drain();

    // 4: reserved packet discarded with one err, then a response
    hdr(8'hC1, F_ERR);
    send(8'h11, 0, 12'h000);
    send(8'h22, DN, 12'h000);
    tail();
    hdr(8'h80, 0);
    send(8'h77, F_RSP | DN, 12'h077);
    tail();
    drain();
    chk("err_count t4", {24'd0, err_count}, 32'd1);

    // 5: reset mid-packet, then clean packets with and without input gaps
    hdr(8'h03, 0);
    send(8'h11, 0, 12'h000);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("err_count after reset", {24'd0, err_count}, 32'd0);
    for (int g = 0; g < 2; g++) begin
      gap_max = g * 3;
      hdr(8'h02, 0);
      send(8'hAA, 0, 12'h000);
      send(8'hBB, F_SMP, 12'hAAB);
      send(8'hCC, F_SMP | DN, 12'hBCC);
      tail();
      drain();
    end
    gap_max = 0;

`ifdef DEPACKETER_CHECKSUM_EN
    // 6: checksum good, bad, then saturation of the error counter
    hdr(8'h40, 0);
    send(8'h5A, F_PPS, 12'h05A);
    send(8'h1A, F_DONE, 12'h000);
    hdr(8'h40, 0);
    send(8'h5A, F_PPS, 12'h05A);
    send(8'h00, F_DONE | F_ERR, 12'h000);
    drain();
    chk("err_count csum", {24'd0, err_count}, 32'd1);
    for (int i = 0; i < 300; i++) begin
      hdr(8'h40, 0);
      send(8'h5A, F_PPS, 12'h05A);
      send(8'h00, F_DONE | F_ERR, 12'h000);
    end
    drain();
    chk("err_count saturate", {24'd0, err_count}, 32'h0000_00FF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
